// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared helpers for the multi-port register file
package rf_pkg;

    localparam int RF_PORT_BASE = 0;

    function automatic int rf_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth,
                                        input bit zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

    // Port k of a packed bus sits at [rf_slice_lo(k, w) +: w]
    function automatic int rf_slice_lo(input int k, input int w);
        return RF_PORT_BASE + k * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one architectural read port with range, zero and bypass rules
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [WIDTH-1:0]  wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [WIDTH-1:0]  wr1_data,
    input  logic [DEPTH-1:0]  busy_vec,
    output logic [WIDTH-1:0]  data,
    output logic              busy
);

    logic             valid;
    logic             hit0;
    logic             hit1;
    logic [WIDTH-1:0] stored;
    logic             stored_busy;

    always_comb begin
        valid       = addr_valid(32'(addr), DEPTH, ZERO_REG != 0);
        hit0        = (BYPASS != 0) && valid && wr0_en && (wr0_addr == addr);
        hit1        = (BYPASS != 0) && valid && wr1_en && (wr1_addr == addr);
        stored      = '0;
        stored_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) begin
                stored      = mem[i];
                stored_busy = busy_vec[i];
            end
        end
        // Lane 1 wins the forward just as it wins the storage write
        if (!valid)    data = '0;
        else if (hit1) data = wr1_data;
        else if (hit0) data = wr0_data;
        else           data = stored;
        busy = valid && stored_busy && !(hit0 || hit1);
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - two-lane register file with busy scoreboard and debug port
module regfile_mp_scoreboard
    import rf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [WIDTH-1:0]         wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [WIDTH-1:0]         wr1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [WIDTH-1:0]         dbg_data,
    output logic [DEPTH-1:0]         busy_vec,
    output logic                     wr_conflict
);

    if (ADDR_W < rf_clog2(DEPTH)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_conflict_q;
    logic             wr_conflict_d;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             issue_ok;

    always_comb begin
        wr0_ok        = wr0_en && addr_valid(32'(wr0_addr), DEPTH, ZERO_REG != 0);
        wr1_ok        = wr1_en && addr_valid(32'(wr1_addr), DEPTH, ZERO_REG != 0);
        issue_ok      = issue_en && addr_valid(32'(issue_addr), DEPTH, ZERO_REG != 0);
        wr_conflict_d = wr0_ok && wr1_ok && (wr0_addr == wr1_addr);
        busy_d        = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr0_ok && (32'(wr0_addr) == i)) begin
                mem_d[i]  = wr0_data;
                busy_d[i] = 1'b0;
            end
            if (wr1_ok && (32'(wr1_addr) == i)) begin
                mem_d[i]  = wr1_data;
                busy_d[i] = 1'b0;
            end
            // A fresh issue supersedes the producer retiring on the same edge
            if (issue_ok && (32'(issue_addr) == i)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_valid(32'(dbg_addr), DEPTH, ZERO_REG != 0) && (32'(dbg_addr) == i))
                dbg_data = mem_q[i];
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = wr_conflict_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .addr    (rd_addr[rf_slice_lo(k, ADDR_W) +: ADDR_W]),
            .mem     (mem_q),
            .wr0_en  (wr0_en),
            .wr0_addr(wr0_addr),
            .wr0_data(wr0_data),
            .wr1_en  (wr1_en),
            .wr1_addr(wr1_addr),
            .wr1_data(wr1_data),
            .busy_vec(busy_q),
            .data    (rd_data[rf_slice_lo(k, WIDTH) +: WIDTH]),
            .busy    (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - directed bench over bypass, no-bypass and 16-deep builds
module tb_regfile_mp_scoreboard;

    logic        clk;
    logic        reset;
    logic        wr0_en, wr1_en, issue_en;
    logic [4:0]  wr0_addr, wr1_addr, issue_addr, dbg_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [9:0]  rd_addr;

    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;
    logic [31:0] dbg_a, dbg_b, dbg_c;
    logic [31:0] busy_a, busy_b;
    logic [15:0] busy_c;
    logic        conf_a, conf_b, conf_c;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_scoreboard #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_a), .busy_vec(busy_a), .wr_conflict(conf_a)
    );

    regfile_mp_scoreboard #(.BYPASS(0)) u_nob (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b), .busy_vec(busy_b), .wr_conflict(conf_b)
    );

    regfile_mp_scoreboard #(.DEPTH(16)) u_d16 (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_c), .busy_vec(busy_c), .wr_conflict(conf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        issue_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        idle();
        wr0_addr   = '0; wr0_data = '0;
        wr1_addr   = '0; wr1_data = '0;
        issue_addr = '0; dbg_addr = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Clean state after reset on every address
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr  = {5'(a), 5'(a)};
            dbg_addr = 5'(a);
            #1;
            check($sformatf("rst_rd_a%0d", a), rd_data_a, 64'h0);
            check($sformatf("rst_dbg_a%0d", a), {32'h0, dbg_a}, 64'h0);
        end
        check("rst_busy", {32'h0, busy_a}, 64'h0);
        check("rst_conf", {63'h0, conf_a}, 64'h0);

        // Same-cycle bypass vs. stored-only read
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
        #1;
        check("byp_rd0", {32'h0, rd_data_a[31:0]}, 64'hDEADBEEF);
        check("byp_dbg", {32'h0, dbg_a}, 64'h0);
        check("nob_rd0", {32'h0, rd_data_b[31:0]}, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("nob_rd0_next", {32'h0, rd_data_b[31:0]}, 64'hDEADBEEF);
        check("byp_dbg_next", {32'h0, dbg_a}, 64'hDEADBEEF);

        // Both lanes on address 7
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rd_addr = {5'd7, 5'd5};
        #1;
        check("coll_byp_rd1", {32'h0, rd_data_a[63:32]}, 64'h22);
        check("coll_conf_pre", {63'h0, conf_a}, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("coll_nob_rd1", {32'h0, rd_data_b[63:32]}, 64'h22);
        check("coll_conf", {63'h0, conf_a}, 64'h1);
        @(negedge clk);
        #1;
        check("coll_conf_clr", {63'h0, conf_a}, 64'h0);

        // Issue then retire on register 3
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        #1;
        check("iss_busy_pre", {62'h0, rd_busy_a}, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("iss_rdbusy_a", {62'h0, rd_busy_a}, 64'h1);
        check("iss_rdbusy_b", {62'h0, rd_busy_b}, 64'h1);
        check("iss_vec", {32'h0, busy_a}, 64'h8);
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h55;
        #1;
        check("ret_rdbusy_byp", {62'h0, rd_busy_a}, 64'h0);
        check("ret_rdbusy_nob", {62'h0, rd_busy_b}, 64'h1);
        check("ret_vec_pre", {32'h0, busy_a}, 64'h8);
        @(negedge clk);
        idle();
        #1;
        check("ret_vec", {32'h0, busy_a}, 64'h0);
        check("ret_rd0", {32'h0, rd_data_b[31:0]}, 64'h55);

        // Issue and retire on the same edge keeps busy
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        dbg_addr = 5'd9;
        @(negedge clk);
        idle();
        #1;
        check("iss_wr_vec", {32'h0, busy_a}, 64'h200);
        check("iss_wr_dbg", {32'h0, dbg_a}, 64'h99);

        // Hardwired zero register
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0; rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        #1;
        check("z_rd_same", {32'h0, rd_data_a[31:0]}, 64'h0);
        check("z_rdbusy", {62'h0, rd_busy_a}, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("z_rd", rd_data_a, 64'h0);
        check("z_dbg", {32'h0, dbg_a}, 64'h0);
        check("z_vec", {32'h0, busy_a}, 64'h200);

        // Out-of-range address on the 16-deep build
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'hABC;
        issue_en = 1'b1; issue_addr = 5'd20;
        rd_addr = {5'd20, 5'd0}; dbg_addr = 5'd20;
        #1;
        check("d16_rd_same", {32'h0, rd_data_c[63:32]}, 64'h0);
        check("d32_rd_same", {32'h0, rd_data_a[63:32]}, 64'hABC);
        @(negedge clk);
        idle();
        #1;
        check("d16_rd", {32'h0, rd_data_c[63:32]}, 64'h0);
        check("d16_dbg", {32'h0, dbg_c}, 64'h0);
        check("d16_vec", {48'h0, busy_c}, 64'h200);
        check("d16_rdbusy", {62'h0, rd_busy_c}, 64'h0);
        check("d32_dbg", {32'h0, dbg_a}, 64'hABC);

        // Asynchronous reset with live state
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'h1;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h2;
        @(negedge clk);
        idle();
        rd_addr = {5'd7, 5'd3}; dbg_addr = 5'd5;
        #1;
        check("pre_rst_conf", {63'h0, conf_a}, 64'h1);
        check("pre_rst_dbg", {32'h0, dbg_a}, 64'hDEADBEEF);
        reset = 1'b0;
        #1;
        check("arst_dbg", {32'h0, dbg_a}, 64'h0);
        check("arst_rd", rd_data_a, 64'h0);
        check("arst_vec", {32'h0, busy_a}, 64'h0);
        check("arst_conf", {63'h0, conf_a}, 64'h0);
        check("arst_rd_nob", rd_data_b, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the single-write, three-read core register file.
- Adds a configurable number of read ports, two write ports with fixed priority, optional write-to-read bypass, and an optional hardwired zero register.
- Adds a per-register busy scoreboard for the pipelined core.
- Sits between the decode/issue stage (reads, busy marking) and writeback (two retire lanes), and keeps a non-bypassed debug read port.

Parameters:
- WIDTH, 32: data width of each register.
- DEPTH, 32: number of registers, 2..64.
- ADDR_W, 5: register address width; must be >= clog2(DEPTH).
- NUM_RD, 2: number of architectural read ports, 1..4.
- ZERO_REG, 1: 1 makes register 0 read as zero, ignore writes and never be busy.
- BYPASS, 1: 1 forwards same-cycle write data to the architectural read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr0_en  in  1  write lane 0 enable.
- wr0_addr  in  ADDR_W  write lane 0 destination.
- wr0_data  in  WIDTH  write lane 0 data.
- wr1_en  in  1  write lane 1 enable; has priority over lane 0.
- wr1_addr  in  ADDR_W  write lane 1 destination.
- wr1_data  in  WIDTH  write lane 1 data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WIDTH  packed read data, same packing.
- rd_busy  out  NUM_RD  per-port flag: the addressed register has a pending producer.
- issue_en  in  1  mark issue_addr busy.
- issue_addr  in  ADDR_W  destination of the newly issued instruction.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  WIDTH  debug read data: stored value, never bypassed.
- busy_vec  out  DEPTH  raw scoreboard bits.
- wr_conflict  out  1  registered pulse: both lanes wrote the same valid address in the previous cycle.

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, busy_vec all 0, wr_conflict 0. Combinational outputs follow from this state. Reset is immediate even mid-write; a write on the edge where reset is released is lost.
- Writes: lane x commits on the rising edge when wrx_en=1 and wrx_addr is valid.
  - Valid means wrx_addr < DEPTH and not (ZERO_REG and wrx_addr=0).
  - Invalid writes are silently dropped.
- Same-address write on both lanes: wr1_data is stored. wr_conflict=1 for exactly the following cycle, then 0 unless the collision repeats.
- Reads: combinational, zero latency.
  - Address >= DEPTH returns 0.
  - Address 0 returns 0 when ZERO_REG=1.
  - With BYPASS=1 and an enabled valid write to the read address in the same cycle, rd_data returns the write data. Lane 1 wins if both lanes hit.
  - With BYPASS=0, reads return the stored value only; new data is visible the cycle after the edge.
- Scoreboard, updated on the rising edge:
  - issue_en with a valid issue_addr sets busy[issue_addr].
  - A committed write to address a clears busy[a].
  - Issue and write to the same address on the same edge: busy stays set, because the new producer supersedes the retiring one.
  - Invalid issue_addr is ignored.
- rd_busy[k] = busy[addr_k] AND NOT (BYPASS and an enabled valid write hits addr_k this cycle).
  - rd_busy[k] is 0 for invalid or zero addresses.
- Debug port: dbg_data is the stored value. Bypass never applies; range and zero rules apply.
- No X propagation: every output is defined for every input combination after reset.

Decomposition:
- Package rf_pkg holds:
  - clog2 function;
  - addr_valid(addr, DEPTH, ZERO_REG) function;
  - the packing-slice convention constant.
- Sub-module rf_read_port: one instance per read port (NUM_RD instances, via generate).
  - Inputs: address, storage array, both write lanes, busy vector.
  - Outputs: data and busy, handling range, zero and bypass rules.
- Storage, the write-priority logic, the scoreboard and the wr_conflict register stay in the top module.

Test Plan:
- Reset deasserted with no writes; read every address on all ports -> all rd_data 0, busy_vec 0, wr_conflict 0.
- Write wr0 addr 5 = 0xDEADBEEF with rd_addr[0]=5 in the same cycle, BYPASS=1 -> rd_data[0]=0xDEADBEEF in that cycle, and dbg_data(5)=0 until after the edge. Repeat with BYPASS=0 -> rd_data[0]=0 that cycle, 0xDEADBEEF the next.
- Same edge: wr0 addr 7 = 0x11 and wr1 addr 7 = 0x22 -> register 7 = 0x22, wr_conflict=1 for one cycle, then 0.
- Issue addr 3, then check rd_addr 3 -> rd_busy=1. Retire write to 3 = 0x55 -> busy clears after the edge; rd_busy=0 already in the write cycle with BYPASS=1.
- Issue addr 9 and write addr 9 on the same edge -> busy_vec[9] remains 1.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 and issue addr 0 -> reads 0, busy_vec[0]=0. DEPTH=16: write addr 20 -> dropped, read addr 20 = 0.
- Assert reset mid-sequence with registers non-zero -> all state 0 immediately, without waiting for a clock edge.
